// File: rtl/load_return_unit_pkg.sv
// load_return_unit_pkg: shared encodings, address map and region decode for the load return path.
package load_return_unit_pkg;

   typedef enum logic [1:0] {
      OP_W = 2'b00,
      OP_H = 2'b01,
      OP_B = 2'b10,
      OP_X = 2'b11
   } dmop_t;

   localparam logic [31:0] DM_END   = 32'h0000_2FFF;
   localparam logic [31:0] TC0_BASE = 32'h0000_7F00;
   localparam logic [31:0] TC1_BASE = 32'h0000_7F10;
   localparam logic [31:0] IG_BASE  = 32'h0000_7F20;

   localparam int R_DM  = 0;
   localparam int R_TC0 = 1;
   localparam int R_TC1 = 2;
   localparam int R_IG  = 3;

   localparam logic [4:0] EXC_ADEL = 5'd4;

   // One-hot {IG, TC1, TC0, DM}; all zero when the address hits no device.
   function automatic logic [3:0] decode_region(input logic [31:0] a);
      logic [3:0] r;
      r        = '0;
      r[R_DM]  = a <= DM_END;
      r[R_TC0] = a >= TC0_BASE && a <= TC0_BASE + 32'd11;
      r[R_TC1] = a >= TC1_BASE && a <= TC1_BASE + 32'd11;
      r[R_IG]  = a >= IG_BASE  && a <= IG_BASE  + 32'd3;
      return r;
   endfunction

endpackage

// File: rtl/load_return_unit_ext.sv
// load_ext: selects the byte/halfword lane of a read word and sign- or zero-extends it.
//   word   in  32  device read word
//   addr   in  2   low address bits picking the lane
//   dmop   in  2   access size (word/half/byte)
//   sign   in  1   1 = sign-extend, 0 = zero-extend
//   result out 32  extended value
module load_ext
   import load_return_unit_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  addr,
   input  logic [1:0]  dmop,
   input  logic        sign,
   output logic [31:0] result
);

   logic [15:0] h;
   logic [7:0]  b;

   always_comb begin
      h = addr[1] ? word[31:16] : word[15:0];
      b = addr == 2'd0 ? word[7:0] :
          addr == 2'd1 ? word[15:8] :
          addr == 2'd2 ? word[23:16] : word[31:24];
      result = dmop == OP_H ? {{16{sign & h[15]}}, h} :
               dmop == OP_B ? {{24{sign & b[7]}}, b} : word;
   end

endmodule

// File: rtl/load_return_unit.sv
// load_return_unit: captures load attributes at M->W and returns the extended device read data.
//   clk, reset      clock and synchronous active-high reset
//   Req             flush; kills the load being captured
//   M_ALUout        M-stage load address
//   M_is_load       M-stage instruction is a load
//   M_DMop          access size (00 word, 01 half, 10 byte, 11 invalid)
//   M_sign          sign-extend select
//   M_ExcCode       nonzero suppresses the load
//   M_rd_en         combinational read strobe to the bridge
//   DM/TC0/TC1/IG_rdata  device read words, valid in W
//   W_load_valid    W_load_data holds a real load result
//   W_load_data     extended load result
//   W_region        one-hot responding device {IG, TC1, TC0, DM}
module load_return_unit
   import load_return_unit_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        Req,
   input  logic [31:0] M_ALUout,
   input  logic        M_is_load,
   input  logic [1:0]  M_DMop,
   input  logic        M_sign,
   input  logic [4:0]  M_ExcCode,
   output logic        M_rd_en,
   input  logic [31:0] DM_rdata,
   input  logic [31:0] TC0_rdata,
   input  logic [31:0] TC1_rdata,
   input  logic [31:0] IG_rdata,
   output logic        W_load_valid,
   output logic [31:0] W_load_data,
   output logic [3:0]  W_region
);

   logic        valid;
   logic [1:0]  addr;
   logic [1:0]  dmop;
   logic        sign;
   logic [3:0]  region;
   logic [31:0] rword;
   logic [31:0] ext;

   assign M_rd_en = M_is_load & (M_ExcCode == 5'd0) & ~Req & (M_DMop != OP_X);

   always_ff @(posedge clk) begin
      if (reset || Req) begin
         valid  <= 1'b0;
         addr   <= '0;
         dmop   <= '0;
         sign   <= 1'b0;
         region <= '0;
      end else begin
         valid  <= M_rd_en;
         addr   <= M_ALUout[1:0];
         dmop   <= M_DMop;
         sign   <= M_sign;
         region <= decode_region(M_ALUout);
      end
   end

   // AND-OR mux on the one-hot region; no region or no valid load yields zero.
   always_comb begin
      rword = ({32{region[R_DM]}}  & DM_rdata)  |
              ({32{region[R_TC0]}} & TC0_rdata) |
              ({32{region[R_TC1]}} & TC1_rdata) |
              ({32{region[R_IG]}}  & IG_rdata);
      rword = valid ? rword : 32'd0;
   end

   load_ext u_ext (
      .word   (rword),
      .addr   (addr),
      .dmop   (dmop),
      .sign   (sign),
      .result (ext)
   );

   assign W_load_valid = valid;
   assign W_load_data  = valid ? ext : 32'd0;
   assign W_region     = region;

endmodule

// File: tb/tb_load_return_unit.sv
// tb_load_return_unit: directed and random checks of load_return_unit against a reference model.
module tb_load_return_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        Req;
   logic [31:0] M_ALUout;
   logic        M_is_load;
   logic [1:0]  M_DMop;
   logic        M_sign;
   logic [4:0]  M_ExcCode;
   logic        M_rd_en;
   logic [31:0] DM_rdata, TC0_rdata, TC1_rdata, IG_rdata;
   logic        W_load_valid;
   logic [31:0] W_load_data;
   logic [3:0]  W_region;

   int checks = 0;
   int errors = 0;

   load_return_unit dut (
      .clk          (clk),
      .reset        (reset),
      .Req          (Req),
      .M_ALUout     (M_ALUout),
      .M_is_load    (M_is_load),
      .M_DMop       (M_DMop),
      .M_sign       (M_sign),
      .M_ExcCode    (M_ExcCode),
      .M_rd_en      (M_rd_en),
      .DM_rdata     (DM_rdata),
      .TC0_rdata    (TC0_rdata),
      .TC1_rdata    (TC1_rdata),
      .IG_rdata     (IG_rdata),
      .W_load_valid (W_load_valid),
      .W_load_data  (W_load_data),
      .W_region     (W_region)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Which device index (0 DM, 1 TC0, 2 TC1, 3 IG) owns an address, -1 for none.
   function automatic int ref_dev(input logic [31:0] a);
      if (a <= 32'h2FFF) return 0;
      if (a >= 32'h7F00 && a < 32'h7F0C) return 1;
      if (a >= 32'h7F10 && a < 32'h7F1C) return 2;
      if (a >= 32'h7F20 && a < 32'h7F24) return 3;
      return -1;
   endfunction

   // Load result from the access rules: shift the lane down, mask, then wrap negative if signed.
   function automatic logic [31:0] ref_data(input logic [31:0] w, input logic [31:0] a,
                                            input logic [1:0] op, input logic s);
      logic [31:0] v;
      int sz;
      if (op == 2'b00) return w;
      sz = (op == 2'b01) ? 16 : 8;
      v = (w >> (sz * int'((a % 4) / (sz / 8)))) & ((32'd1 << sz) - 32'd1);
      if (s && v >= (32'd1 << (sz - 1))) v = v - (32'd1 << sz);
      return v;
   endfunction

   task automatic step(input logic rst, input logic req, input logic ld, input logic [31:0] a,
                       input logic [1:0] op, input logic s, input logic [4:0] exc,
                       input logic [31:0] dm, input logic [31:0] t0, input logic [31:0] t1,
                       input logic [31:0] ig);
      logic        ev;
      logic [3:0]  er;
      logic [31:0] ed;
      logic [31:0] words [4];
      int          d;
      @(negedge clk);
      reset = rst; Req = req; M_is_load = ld; M_ALUout = a; M_DMop = op; M_sign = s; M_ExcCode = exc;
      DM_rdata = $urandom; TC0_rdata = $urandom; TC1_rdata = $urandom; IG_rdata = $urandom;
      #1;
      chk("rd_en", {31'd0, M_rd_en}, {31'd0, ld && exc == 0 && !req && op != 2'b11});
      @(posedge clk);
      #1;
      DM_rdata = dm; TC0_rdata = t0; TC1_rdata = t1; IG_rdata = ig;
      words[0] = dm; words[1] = t0; words[2] = t1; words[3] = ig;
      d  = ref_dev(a);
      ev = !rst && ld && exc == 0 && !req && op != 2'b11;
      er = (rst || req || d < 0) ? 4'd0 : 4'(1 << d);
      ed = (!ev || d < 0) ? 32'd0 : ref_data(words[d], a, op, s);
      #1;
      chk("valid", {31'd0, W_load_valid}, {31'd0, ev});
      chk("region", {28'd0, W_region}, {28'd0, er});
      chk("data", W_load_data, ed);
   endtask

   initial begin
      reset = 1'b1; Req = 1'b0; M_ALUout = '0; M_is_load = 1'b0; M_DMop = '0; M_sign = 1'b0;
      M_ExcCode = '0; DM_rdata = '0; TC0_rdata = '0; TC1_rdata = '0; IG_rdata = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_valid", {31'd0, W_load_valid}, 32'd0);
      chk("reset_region", {28'd0, W_region}, 32'd0);
      chk("reset_data", W_load_data, 32'd0);

      // lb signed, lhu, lh
      step(0, 0, 1, 32'h13, 2'b10, 1, 0, 32'h80FF_1234, 0, 0, 0);
      chk("lb_fixed", W_load_data, 32'hFFFF_FF80);
      step(0, 0, 1, 32'h02, 2'b01, 0, 0, 32'h9ABC_5678, 0, 0, 0);
      chk("lhu_fixed", W_load_data, 32'h0000_9ABC);
      step(0, 0, 1, 32'h02, 2'b01, 1, 0, 32'h9ABC_5678, 0, 0, 0);
      chk("lh_fixed", W_load_data, 32'hFFFF_9ABC);
      // timer / IG word loads
      step(0, 0, 1, 32'h7F14, 2'b00, 0, 0, 32'h1111_1111, 32'h2222_2222, 32'h0000_00AA, 32'h3333_3333);
      chk("tc1_fixed", W_load_data, 32'h0000_00AA);
      step(0, 0, 1, 32'h7F20, 2'b00, 0, 0, 32'h1111_1111, 32'h2222_2222, 32'h4444_4444, 32'h5A5A_1234);
      chk("ig_fixed", W_load_data, 32'h5A5A_1234);
      // suppressed loads
      step(0, 0, 1, 32'h40, 2'b00, 0, 5'd4, 32'hDEAD_BEEF, 0, 0, 0);
      step(0, 1, 1, 32'h40, 2'b00, 0, 0, 32'hDEAD_BEEF, 0, 0, 0);
      step(0, 0, 1, 32'h40, 2'b11, 0, 0, 32'hDEAD_BEEF, 0, 0, 0);
      // boundaries
      step(0, 0, 1, 32'h2FFF, 2'b10, 0, 0, 32'hC1C2_C3C4, 0, 0, 0);
      chk("dm_end_byte", W_load_data, 32'h0000_00C1);
      step(0, 0, 1, 32'h3000, 2'b00, 0, 5'd4, 32'hDEAD_BEEF, 0, 0, 0);
      step(0, 0, 1, 32'h7F0B, 2'b10, 1, 0, 0, 32'h8000_0000, 0, 0);
      step(0, 0, 1, 32'h7F0C, 2'b00, 0, 0, 32'h1, 32'h2, 32'h3, 32'h4);
      // back-to-back lw, lb, lh
      step(0, 0, 1, 32'h100, 2'b00, 0, 0, 32'h0102_0304, 0, 0, 0);
      step(0, 0, 1, 32'h101, 2'b10, 1, 0, 32'hFFFF_F7FF, 0, 0, 0);
      chk("b2b_lb", W_load_data, 32'hFFFF_FFF7);
      step(0, 0, 1, 32'h102, 2'b01, 1, 0, 32'h7FFF_8000, 0, 0, 0);
      chk("b2b_lh", W_load_data, 32'h0000_7FFF);
      // reset while a valid load is in flight
      step(0, 0, 1, 32'h7F04, 2'b00, 0, 0, 0, 32'hABCD_0000, 0, 0);
      step(1, 0, 1, 32'h7F04, 2'b00, 0, 0, 0, 32'hABCD_0000, 0, 0);

      for (int i = 0; i < 300; i++) begin
         logic [31:0] a;
         int pick;
         pick = $urandom_range(0, 4);
         a = pick == 0 ? 32'($urandom_range(0, 32'h2FFF)) :
             pick == 1 ? 32'h7F00 + 32'($urandom_range(0, 15)) :
             pick == 2 ? 32'h7F10 + 32'($urandom_range(0, 15)) :
             pick == 3 ? 32'h7F20 + 32'($urandom_range(0, 7)) : $urandom;
         step($urandom_range(0, 29) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 7) != 0, a,
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 7) == 0 ? 5'($urandom_range(1, 31)) : 5'd0,
              $urandom, $urandom, $urandom, $urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
